// File: rtl/sw_debounce.sv
// Switch input peripheral: two-flop synchroniser, tick-sampled debounce history,
// sticky edge flags with W1C clear, and a maskable registered interrupt.
module sw_debounce #(
  parameter int TICK_DIV = 20000,
  parameter int HIST     = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic [15:0]       pin_sw_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              irq_o
);

  localparam int NPIN  = 16;
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]  cnt_p0;
  logic              vld_p1;
  logic [NPIN-1:0]   sync_p0, sync_p1;
  logic [HIST-1:0]   hist_p2   [NPIN];
  logic [HIST-1:0]   hist_nxt  [NPIN];
  logic [NPIN-1:0]   state_p2, state_nxt, rise, fall;
  logic [2*NPIN-1:0] edge_p3, edge_nxt, irq_en_p3, irq_en_nxt, w1c_mask;
  logic              irq_p4;
  logic              rd_act, wr_act, wr_edge, wr_ien;
  logic [1:0]        sel;
  logic              unused_bits;

  // Only a full run of equal samples moves the state; anything mixed holds it.
  function automatic logic deb_next(input logic [HIST-1:0] h, input logic cur);
    if (&h)
      return 1'b1;
    else if (~|h)
      return 1'b0;
    return cur;
  endfunction

  // stage 0: prescaler; vld_p1 marks the sample tick
  assign vld_p1 = (cnt_p0 == CNT_MAX);

  // stage 2: history shift and debounced state using the incoming sample
  always_comb begin
    for (int i = 0; i < NPIN; i++) begin
      hist_nxt[i]  = {hist_p2[i][HIST-2:0], sync_p1[i]};
      state_nxt[i] = vld_p1 ? deb_next(hist_nxt[i], state_p2[i]) : state_p2[i];
    end
    rise = state_nxt & ~state_p2;
    fall = ~state_nxt & state_p2;
  end

  // stage 3: bus decode, sticky flags (set beats same-cycle clear) and mask
  assign rd_act      = en_i & r_en_i;
  assign wr_act      = en_i & w_en_i;
  assign sel         = addr_i[3:2];
  assign wr_edge     = wr_act && (sel == 2'd1);
  assign wr_ien      = wr_act && (sel == 2'd2);
  assign w1c_mask    = wr_edge ? w_data_i[2*NPIN-1:0] : '0;
  assign edge_nxt    = (edge_p3 & ~w1c_mask) | {fall, rise};
  assign irq_en_nxt  = wr_ien ? w_data_i[2*NPIN-1:0] : irq_en_p3;
  assign unused_bits = ^{addr_i[ADDR_W-1:4], addr_i[1:0]};

  always_comb begin
    r_data_o = '0;
    if (rd_act) begin
      case (sel)
        2'd0:    r_data_o = DATA_W'({16'h0000, state_p2});
        2'd1:    r_data_o = DATA_W'(edge_p3);
        2'd2:    r_data_o = DATA_W'(irq_en_p3);
        default: r_data_o = DATA_W'({16'h0000, sync_p1});
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0    <= '0;
      sync_p0   <= '0;
      sync_p1   <= '0;
      for (int i = 0; i < NPIN; i++) hist_p2[i] <= '0;
      state_p2  <= '0;
      edge_p3   <= '0;
      irq_en_p3 <= '0;
      irq_p4    <= 1'b0;
    end else begin
      cnt_p0    <= vld_p1 ? '0 : cnt_p0 + CNT_W'(1);
      sync_p0   <= pin_sw_i;
      sync_p1   <= sync_p0;
      if (vld_p1)
        for (int i = 0; i < NPIN; i++) hist_p2[i] <= hist_nxt[i];
      state_p2  <= state_nxt;
      edge_p3   <= edge_nxt;
      irq_en_p3 <= irq_en_nxt;
      // stage 4: interrupt follows the registered flags one clock later
      irq_p4    <= |(edge_p3 & irq_en_p3);
    end
  end

  assign irq_o = irq_p4;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=4, HIST=3: reset, debounce timing,
// bounce rejection, W1C/set collision, interrupt masking and bus decode.
module tb_sw_debounce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, r_en = 1'b0, w_en = 1'b0;
  logic [31:0] addr = '0, w_data = '0;
  logic [15:0] pins = '0;
  logic [31:0] r_data;
  logic        irq;
  int          n_tests = 0, n_fail = 0;
  int          cyc;
  logic [31:0] d;
  logic        found;

  sw_debounce #(.TICK_DIV(4), .HIST(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .r_en_i(r_en), .addr_i(addr),
    .w_en_i(w_en), .w_data_i(w_data), .pin_sw_i(pins),
    .r_data_o(r_data), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // bench-side cycle count since reset release; sample ticks land where cyc%4==0
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] v);
    en = 1'b1; r_en = 1'b1; addr = {28'h0, idx, 2'b00};
    #1;
    v = r_data;
    en = 1'b0; r_en = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    rd(idx, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] v);
    en = 1'b1; w_en = 1'b1; addr = {28'h0, idx, 2'b00}; w_data = v;
    @(posedge clk);
    #1;
    en = 1'b0; w_en = 1'b0; w_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(2);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    rdchk("rst_state", 2'd0, 32'h0);
    rdchk("rst_edge",  2'd1, 32'h0);
    rdchk("rst_ien",   2'd2, 32'h0);
    rdchk("rst_raw",   2'd3, 32'h0);

    // pin 0 rises; ticks shift at cycles 4, 8, 12
    pins = 16'h0001;
    step(1);
    rdchk("raw_1clk", 2'd3, 32'h0);
    step(1);
    rdchk("raw_2clk", 2'd3, 32'h1);
    step(9);
    rdchk("state_c11", 2'd0, 32'h0);
    step(1);
    rdchk("state_c12", 2'd0, 32'h1);
    rdchk("edge_rise", 2'd1, 32'h1);
    step(1);
    chk("irq_masked", {31'h0, irq}, 32'h0);

    // asynchronous reset mid-count with pin still high
    #2;
    rst_n = 1'b0;
    #1;
    rdchk("mid_rst_state", 2'd0, 32'h0);
    rdchk("mid_rst_edge",  2'd1, 32'h0);
    rdchk("mid_rst_raw",   2'd3, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(11);
    rdchk("rel_state_c11", 2'd0, 32'h0);
    step(1);
    rdchk("rel_state_c12", 2'd0, 32'h1);
    rdchk("rel_edge_rise", 2'd1, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    rdchk("init_clear", 2'd1, 32'h0);

    // pin 3 bounces with a 6-clock period; never three equal samples
    for (int k = 0; k < 40; k++) begin
      pins[3] = ((k / 3) % 2) == 0;
      step(1);
      rdchk("bounce_state", 2'd0, 32'h1);
      rdchk("bounce_edge",  2'd1, 32'h0);
    end
    pins[3] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      rdchk("settle_state", 2'd0, 32'h1);
      rdchk("settle_edge",  2'd1, 32'h0);
    end

    // pin 0 falls at cycle c (c%4==0): state drops at edge c+12, collide W1C there
    while ((cyc % 4) != 0) step(1);
    pins[0] = 1'b0;
    step(11);
    rdchk("pre_fall_state", 2'd0, 32'h1);
    rdchk("pre_fall_edge",  2'd1, 32'h0);
    wr(2'd1, 32'h0001_0000);
    rdchk("fall_state",    2'd0, 32'h0);
    rdchk("collide_edge",  2'd1, 32'h0001_0000);
    wr(2'd1, 32'h0001_0000);
    rdchk("fall_cleared",  2'd1, 32'h0);

    // interrupt on pin 0 rise
    wr(2'd2, 32'h0000_0001);
    pins[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1);
      rd(2'd1, d);
      if (d[0]) found = 1'b1;
    end
    chk("rise_seen", {31'h0, found}, 32'h1);
    chk("irq_same_clk", {31'h0, irq}, 32'h0);
    step(1);
    chk("irq_next_clk", {31'h0, irq}, 32'h1);
    wr(2'd1, 32'h0);
    rdchk("w0_edge", 2'd1, 32'h1);
    chk("w0_irq", {31'h0, irq}, 32'h1);
    wr(2'd1, 32'h0000_0001);
    rdchk("w1c_edge", 2'd1, 32'h0);
    chk("w1c_irq_lag", {31'h0, irq}, 32'h1);
    step(1);
    chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

    // read-only registers, mask readback, bus select
    wr(2'd0, 32'hFFFF_FFFF);
    rdchk("ro_state", 2'd0, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    rdchk("ro_raw", 2'd3, 32'h1);
    wr(2'd2, 32'hFFFF_FFFF);
    rdchk("ien_rb", 2'd2, 32'hFFFF_FFFF);
    en = 1'b0; r_en = 1'b1; addr = 32'h8;
    #1;
    chk("no_sel_read", r_data, 32'h0);
    r_en = 1'b0; en = 1'b1;
    #1;
    chk("no_strobe_read", r_data, 32'h0);
    en = 1'b0; w_en = 1'b1; w_data = 32'h0;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    rdchk("no_sel_write", 2'd2, 32'hFFFF_FFFF);
    rdchk("final_edge", 2'd1, 32'h0);
    step(1);
    chk("final_irq", {31'h0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
